// File: rtl/sync_fifo_ex.sv
// sync_fifo_ex: single-clock FIFO with 2^ADDR_WIDTH usable words, fill count,
// almost-full/almost-empty thresholds, optional first-word-fall-through read
// mode and sticky overflow/underflow flags.
//
// Ports:
//   clk           rising-edge clock for all state
//   reset         synchronous active-high; clears pointers, count, flags, output
//   data_w/req_w  write data / write request (ignored while full)
//   full          count == 2^ADDR_WIDTH
//   almost_full   count >= AFULL_TH
//   data_r        read data (standard: registered RAM output; FWFT: head word)
//   req_r         read request (FWFT: pop of the head word)
//   empty         no readable word
//   almost_empty  count <= AEMPTY_TH
//   count         words held, including any prefetched FWFT words
//   overflow      sticky, set by req_w while full
//   underflow     sticky, set by req_r while empty
//   clear_err     clears overflow/underflow; a new set wins over the clear
module sync_fifo_ex #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned FWFT       = 0,
    parameter int unsigned AFULL_TH   = (1 << ADDR_WIDTH) - 4,
    parameter int unsigned AEMPTY_TH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_w,
    input  logic                  req_w,
    output logic                  full,
    output logic                  almost_full,
    output logic [DATA_WIDTH-1:0] data_r,
    input  logic                  req_r,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clear_err
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned CW    = ADDR_WIDTH + 1;
    localparam int unsigned PW    = ADDR_WIDTH + 1;

    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_TH);
    localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_TH);
    localparam bit            FWFT_MODE = (FWFT != 0);

    // Storage (behaves as a dual-port RAM with both ports on clk)
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // State registers
    logic [PW-1:0]         wp;
    logic [PW-1:0]         rp;
    logic [DATA_WIDTH-1:0] ram_q;   // RAM registered read data
    logic                  mid_v;   // FWFT: ram_q holds a prefetched word
    logic [DATA_WIDTH-1:0] head;    // FWFT: oldest word, presented on data_r
    logic                  head_v;

    // Next-state values
    logic                  we;
    logic                  rd_acc;
    logic                  ram_rd;
    logic                  ram_ne;
    logic                  mid_move;
    logic [PW-1:0]         wp_n;
    logic [PW-1:0]         rp_n;
    logic [CW-1:0]         count_n;
    logic                  mid_v_n;
    logic [DATA_WIDTH-1:0] head_n;
    logic                  head_v_n;
    logic                  empty_n;
    logic                  ovf_n;
    logic                  unf_n;

    // Acceptance, prefetch pipeline and next-state computation
    always_comb begin
        we       = 1'b0;
        rd_acc   = 1'b0;
        ram_rd   = 1'b0;
        mid_move = 1'b0;
        wp_n     = wp;
        rp_n     = rp;
        count_n  = count;
        mid_v_n  = mid_v;
        head_n   = head;
        head_v_n = head_v;
        empty_n  = empty;
        ram_ne   = (wp != rp);

        we = req_w & ~full;

        if (FWFT_MODE) begin
            rd_acc   = req_r & head_v;
            // Prefetched word advances when the head slot is free or being popped
            mid_move = mid_v & (~head_v | rd_acc);
            // Keep the prefetch stage busy so pops can stream one per clock
            ram_rd   = ram_ne & (~mid_v | mid_move);
            if (~head_v | rd_acc) begin
                head_v_n = mid_v;
                if (mid_v) begin
                    head_n = ram_q;
                end
            end
            mid_v_n = ram_rd | (mid_v & ~mid_move);
            empty_n = ~head_v_n;
        end else begin
            rd_acc = req_r & ~empty;
            ram_rd = rd_acc;
        end

        if (we) begin
            wp_n = wp + PW'(1);
        end
        if (ram_rd) begin
            rp_n = rp + PW'(1);
        end

        case ({we, rd_acc})
            2'b10:   count_n = count + CW'(1);
            2'b01:   count_n = count - CW'(1);
            default: count_n = count;
        endcase

        if (!FWFT_MODE) begin
            empty_n = (count_n == '0);
        end

        // Set wins over clear
        ovf_n = (req_w & full)  | (overflow  & ~clear_err);
        unf_n = (req_r & empty) | (underflow & ~clear_err);
    end

    // Control and status registers
    always_ff @(posedge clk) begin
        if (reset) begin
            wp           <= '0;
            rp           <= '0;
            count        <= '0;
            ram_q        <= '0;
            mid_v        <= 1'b0;
            head         <= '0;
            head_v       <= 1'b0;
            full         <= 1'b0;
            almost_full  <= 1'b0;
            empty        <= 1'b1;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            wp           <= wp_n;
            rp           <= rp_n;
            count        <= count_n;
            mid_v        <= mid_v_n;
            head         <= head_n;
            head_v       <= head_v_n;
            full         <= (count_n == DEPTH_C);
            almost_full  <= (count_n >= AFULL_C);
            empty        <= empty_n;
            almost_empty <= (count_n <= AEMPTY_C);
            overflow     <= ovf_n;
            underflow    <= unf_n;
            if (ram_rd) begin
                ram_q <= mem[rp[ADDR_WIDTH-1:0]];
            end
        end
    end

    // RAM write port
    always_ff @(posedge clk) begin
        if (we && !reset) begin
            mem[wp[ADDR_WIDTH-1:0]] <= data_w;
        end
    end

    assign data_r = FWFT_MODE ? head : ram_q;

endmodule

// File: tb/tb_sync_fifo_ex.sv
// Randomised scoreboard bench for sync_fifo_ex: one standard-mode instance
// (depth 16, AFULL_TH=12, AEMPTY_TH=2) and one FWFT instance (depth 16,
// default thresholds 12/4), each with a queue-based reference model.
module tb_sync_fifo_ex;

    localparam int     DEPTH = 16;
    localparam longint P     = 10;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- standard-mode instance ----------------
    logic       a_reset, a_req_w, a_req_r, a_clear;
    logic [7:0] a_data_w, a_data_r;
    logic       a_full, a_af, a_empty, a_ae, a_ovf, a_unf;
    logic [4:0] a_count;

    sync_fifo_ex #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(0), .AFULL_TH(12), .AEMPTY_TH(2)) u_a (
        .clk(clk), .reset(a_reset), .data_w(a_data_w), .req_w(a_req_w),
        .full(a_full), .almost_full(a_af), .data_r(a_data_r), .req_r(a_req_r),
        .empty(a_empty), .almost_empty(a_ae), .count(a_count),
        .overflow(a_ovf), .underflow(a_unf), .clear_err(a_clear)
    );

    logic [7:0] a_mq[$];    // words held
    logic [7:0] a_exp[$];   // words read, awaiting the output register
    logic [7:0] a_dr_m;
    bit a_ovf_m, a_unf_m, a_rd_flag, a_rst_flag, a_en;

    task automatic a_step(input bit w, input bit r, input logic [7:0] d,
                          input bit clr = 1'b0, input bit rst = 1'b0);
        bit fullp, emptyp;
        a_req_w = w; a_req_r = r; a_data_w = d; a_clear = clr; a_reset = rst;
        fullp  = (a_mq.size() == DEPTH);
        emptyp = (a_mq.size() == 0);
        @(posedge clk);
        if (rst) begin
            a_mq.delete();
            a_ovf_m = 0; a_unf_m = 0; a_rst_flag = 1; a_rd_flag = 0;
        end else begin
            a_rd_flag = r && !emptyp;
            if (r && !emptyp) a_exp.push_back(a_mq.pop_front());
            if (w && !fullp)  a_mq.push_back(d);
            a_ovf_m = (w && fullp)  || (a_ovf_m && !clr);
            a_unf_m = (r && emptyp) || (a_unf_m && !clr);
        end
        #1;
        a_req_w = 0; a_req_r = 0; a_clear = 0; a_reset = 0;
    endtask

    always @(negedge clk) begin
        if (a_en) begin
            if (a_rst_flag) begin
                a_exp.delete(); a_dr_m = 8'h00; a_rst_flag = 0;
            end
            if (a_rd_flag) begin
                if (a_exp.size() > 0) a_dr_m = a_exp.pop_front();
                a_rd_flag = 0;
            end
            chk("a_data_r", longint'(a_data_r), longint'(a_dr_m));
            chk("a_count", longint'(a_count), longint'(a_mq.size()));
            chk("a_full", longint'(a_full), longint'(a_mq.size() == DEPTH));
            chk("a_empty", longint'(a_empty), longint'(a_mq.size() == 0));
            chk("a_almost_full", longint'(a_af), longint'(a_mq.size() >= 12));
            chk("a_almost_empty", longint'(a_ae), longint'(a_mq.size() <= 2));
            chk("a_overflow", longint'(a_ovf), longint'(a_ovf_m));
            chk("a_underflow", longint'(a_unf), longint'(a_unf_m));
        end
    end

    // ---------------- FWFT instance ----------------
    logic       b_reset, b_req_w, b_req_r, b_clear;
    logic [7:0] b_data_w, b_data_r;
    logic       b_full, b_af, b_empty, b_ae, b_ovf, b_unf;
    logic [4:0] b_count;

    sync_fifo_ex #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(1)) u_b (
        .clk(clk), .reset(b_reset), .data_w(b_data_w), .req_w(b_req_w),
        .full(b_full), .almost_full(b_af), .data_r(b_data_r), .req_r(b_req_r),
        .empty(b_empty), .almost_empty(b_ae), .count(b_count),
        .overflow(b_ovf), .underflow(b_unf), .clear_err(b_clear)
    );

    typedef struct {
        logic [7:0] d;
        longint     t;   // time of the edge that wrote the word
    } ent_t;

    ent_t b_mq[$];
    bit b_ovf_m, b_unf_m, b_fresh, b_en;

    // Oldest word is presented two edges after it was written
    function automatic bit b_vis(input longint edge_t);
        return (b_mq.size() > 0) && (b_mq[0].t <= edge_t - 2 * P);
    endfunction

    task automatic b_step(input bit w, input bit r, input logic [7:0] d,
                          input bit clr = 1'b0, input bit rst = 1'b0);
        bit fullp, emptyp;
        longint e_t;
        ent_t e;
        b_req_w = w; b_req_r = r; b_data_w = d; b_clear = clr; b_reset = rst;
        @(posedge clk);
        e_t = longint'($time);
        if (rst) begin
            b_mq.delete();
            b_ovf_m = 0; b_unf_m = 0; b_fresh = 1;
        end else begin
            emptyp = !b_vis(e_t - P);
            fullp  = (b_mq.size() == DEPTH);
            if (r && !emptyp) void'(b_mq.pop_front());
            if (w && !fullp) begin
                e.d = d; e.t = e_t;
                b_mq.push_back(e);
            end
            b_ovf_m = (w && fullp)  || (b_ovf_m && !clr);
            b_unf_m = (r && emptyp) || (b_unf_m && !clr);
        end
        #1;
        b_req_w = 0; b_req_r = 0; b_clear = 0; b_reset = 0;
    endtask

    always @(negedge clk) begin
        if (b_en) begin
            chk("b_empty", longint'(b_empty), longint'(!b_vis(longint'($time) - P / 2)));
            if (!b_empty) begin
                if (b_mq.size() > 0) chk("b_data_r", longint'(b_data_r), longint'(b_mq[0].d));
                b_fresh = 0;
            end else if (b_fresh) begin
                chk("b_data_r_reset", longint'(b_data_r), 0);
            end
            chk("b_count", longint'(b_count), longint'(b_mq.size()));
            chk("b_full", longint'(b_full), longint'(b_mq.size() == DEPTH));
            chk("b_almost_full", longint'(b_af), longint'(b_mq.size() >= 12));
            chk("b_almost_empty", longint'(b_ae), longint'(b_mq.size() <= 4));
            chk("b_overflow", longint'(b_ovf), longint'(b_ovf_m));
            chk("b_underflow", longint'(b_unf), longint'(b_unf_m));
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        a_reset = 0; a_req_w = 0; a_req_r = 0; a_clear = 0; a_data_w = 0;
        b_reset = 0; b_req_w = 0; b_req_r = 0; b_clear = 0; b_data_w = 0;
        a_en = 0; b_en = 0; a_rd_flag = 0; a_rst_flag = 0; a_dr_m = 0;

        a_step(0, 0, 8'h00, 0, 1); a_en = 1;
        a_step(0, 0, 8'h00, 0, 1);
        b_step(0, 0, 8'h00, 0, 1); b_en = 1;
        b_step(0, 0, 8'h00, 0, 1);

        // Standard: fill to full, overflow, drain in order, underflow
        for (int i = 0; i < 16; i++) a_step(1, 0, 8'(i));
        a_step(1, 0, 8'h77);
        a_step(0, 0, 8'h00, 1);
        for (int i = 0; i < 16; i++) a_step(0, 1, 8'h00);
        a_step(0, 0, 8'h00);
        a_step(0, 1, 8'h00);
        a_step(0, 0, 8'h00, 1);
        // Both requests at empty, then at full
        a_step(1, 1, 8'h5A);
        a_step(0, 0, 8'h00, 1);
        for (int i = 0; i < 15; i++) a_step(1, 0, 8'(8'h80 + i));
        a_step(1, 1, 8'hEE);
        a_step(0, 0, 8'h00, 1);
        while (a_mq.size() > 0) a_step(0, 1, 8'h00);

        // Pointer wrap with occupancy kept between 3 and 12
        for (int i = 0; i < 6; i++) a_step(1, 0, 8'($urandom));
        for (int i = 0; i < 40; i++) begin
            if (a_mq.size() <= 3)       a_step(1, 0, 8'($urandom));
            else if (a_mq.size() >= 12) a_step(0, 1, 8'h00);
            else a_step(1'($urandom), 1'($urandom), 8'($urandom));
        end

        // Random traffic with alternating write/read bias
        for (int i = 0; i < 300; i++) begin
            bit wb;
            wb = ((i / 50) % 2) == 0;
            a_step(($urandom % 10) < (wb ? 8 : 3), ($urandom % 10) < (wb ? 3 : 8),
                   8'($urandom), ($urandom % 25) == 0);
        end

        // Reset mid-stream at count 7 together with a write
        while (a_mq.size() > 0) a_step(0, 1, 8'h00);
        for (int i = 0; i < 7; i++) a_step(1, 0, 8'(8'h40 + i));
        a_step(1, 0, 8'h99, 0, 1);
        a_step(1, 0, 8'h3C);
        a_step(0, 0, 8'h00);
        a_step(0, 1, 8'h00);
        a_step(0, 0, 8'h00);

        // FWFT: single-word latency and pop
        b_step(1, 0, 8'hA5);
        for (int i = 0; i < 3; i++) b_step(0, 0, 8'h00);
        b_step(0, 1, 8'h00);
        b_step(0, 0, 8'h00);
        b_step(0, 1, 8'h00);

        // FWFT: stream 10 words with req_r held high
        for (int i = 0; i < 10; i++) b_step(1, 0, 8'(8'h10 + i));
        for (int i = 0; i < 12; i++) b_step(0, 1, 8'h00);

        // FWFT: full boundary and both requests at full/empty
        for (int i = 0; i < 17; i++) b_step(1, 0, 8'(8'hC0 + i));
        b_step(0, 0, 8'h00);
        b_step(1, 1, 8'hEE);
        b_step(0, 0, 8'h00, 1);
        while (b_mq.size() > 0) b_step(0, 1, 8'h00);
        b_step(1, 1, 8'h6B);
        for (int i = 0; i < 3; i++) b_step(0, 0, 8'h00);

        // FWFT: random traffic
        for (int i = 0; i < 300; i++) begin
            bit wb;
            wb = ((i / 40) % 2) == 0;
            b_step(($urandom % 10) < (wb ? 8 : 3), ($urandom % 10) < (wb ? 4 : 9),
                   8'($urandom), ($urandom % 25) == 0);
        end

        // FWFT: reset mid-stream at count 7, then a round trip
        while (b_mq.size() > 0) b_step(0, 1, 8'h00);
        for (int i = 0; i < 7; i++) b_step(1, 0, 8'(8'h60 + i));
        b_step(1, 0, 8'h99, 0, 1);
        b_step(1, 0, 8'hC3);
        for (int i = 0; i < 3; i++) b_step(0, 0, 8'h00);
        b_step(0, 1, 8'h00);
        b_step(0, 0, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
